// File: rtl/mem_arbiter.sv
// mem_arbiter: the only owner of the byte-wide RAM/IO port.
// Two requesters share the port. The ICache fetches 4-byte words. The LSB issues
// 1/2/4-byte loads and stores. Every transfer is split into one RAM cycle per byte.
// Read data is assembled little-endian. Speculative reads are dropped on a
// misprediction flush. Stores to the IO region stall while the UART buffer is full.
//
// Ports
//   clk_i, rst_i            clock; rst_i is asynchronous and active-low
//   rdy_i                   global enable; low freezes all state and outputs
//   jump_wrong_i            misprediction flush
//   icache_req/addr_i       word fetch request, held until icache_done_o
//   icache_done/data_o      one-cycle completion pulse and fetched word
//   lsb_req/wr/len/addr/wdata_i  load/store request, held until lsb_done_o
//   lsb_done/rdata_o        completion pulse and zero-extended load data
//   mem_din_i, mem_dout_o, mem_a_o, mem_wr_o  synchronous byte RAM port
//   io_buffer_full_i        UART buffer full
module mem_arbiter #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rdy_i,
  input  logic              jump_wrong_i,
  input  logic              icache_req_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  output logic              icache_done_o,
  output logic [31:0]       icache_data_o,
  input  logic              lsb_req_i,
  input  logic              lsb_wr_i,
  input  logic [1:0]        lsb_len_i,
  input  logic [ADDR_W-1:0] lsb_addr_i,
  input  logic [31:0]       lsb_wdata_i,
  output logic              lsb_done_o,
  output logic [31:0]       lsb_rdata_o,
  input  logic [7:0]        mem_din_i,
  output logic [7:0]        mem_dout_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_wr_o,
  input  logic              io_buffer_full_i
);

  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_e;
  typedef enum logic {G_ICACHE = 1'b0, G_LSB = 1'b1} grant_e;

  state_e            state_q;
  grant_e            last_grant_q;
  logic [2:0]        cnt_q;       // byte step within the transfer
  logic [2:0]        nbytes_q;    // transfer length N
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              io_q;        // latched store targets the IO region
  logic [31:0]       buf_q;       // read assembly buffer

  logic              icache_done_q, lsb_done_q, mem_wr_q;
  logic [31:0]       icache_data_q, lsb_rdata_q;
  logic [7:0]        mem_dout_q;
  logic [ADDR_W-1:0] mem_a_q;

  assign icache_done_o = icache_done_q;
  assign icache_data_o = icache_data_q;
  assign lsb_done_o    = lsb_done_q;
  assign lsb_rdata_o   = lsb_rdata_q;
  assign mem_dout_o    = mem_dout_q;
  assign mem_a_o       = mem_a_q;
  assign mem_wr_o      = mem_wr_q;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   len_bytes = 3'd1;
      2'b01:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;   // 2'b11 behaves as a word
    endcase
  endfunction

  // A flush blocks reads in IDLE, but a store is already committed.
  logic if_ok, ls_ok, pick_ls;
  assign if_ok   = icache_req_i && !jump_wrong_i;
  assign ls_ok   = lsb_req_i && (lsb_wr_i || !jump_wrong_i);
  // When both requesters contend, the one not served last wins.
  assign pick_ls = ls_ok && (!if_ok || (last_grant_q == G_ICACHE));

  // The RAM is two cycles behind the address, so step k holds byte k-2.
  // The index wraps mod 4, which also covers step 5 of a word read.
  logic [1:0]  rd_idx;
  logic [31:0] rd_word;
  assign rd_idx = cnt_q[1:0] - 2'd2;
  always_comb begin
    rd_word = buf_q;
    rd_word[{rd_idx, 3'b000} +: 8] = mem_din_i;
  end

  logic io_stall_acc;
  assign io_stall_acc = (lsb_addr_i >= IO_BASE) && io_buffer_full_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      last_grant_q  <= G_ICACHE;
      cnt_q         <= '0;
      nbytes_q      <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      io_q          <= 1'b0;
      buf_q         <= '0;
      icache_done_q <= 1'b0;
      icache_data_q <= '0;
      lsb_done_q    <= 1'b0;
      lsb_rdata_q   <= '0;
      mem_dout_q    <= '0;
      mem_a_q       <= '0;
      mem_wr_q      <= 1'b0;
    end else if (rdy_i) begin
      case (state_q)
        IDLE: begin
          if (if_ok || ls_ok) begin
            cnt_q   <= 3'd1;
            buf_q   <= '0;
            mem_a_q <= pick_ls ? lsb_addr_i : icache_addr_i;
            if (pick_ls) begin
              last_grant_q <= G_LSB;
              addr_q       <= lsb_addr_i;
              wdata_q      <= lsb_wdata_i;
              nbytes_q     <= len_bytes(lsb_len_i);
              io_q         <= (lsb_addr_i >= IO_BASE);
              if (lsb_wr_i) begin
                state_q <= LS_WR;
                if (io_stall_acc) begin
                  // Byte 0 is not yet issued, so the step stays at 0.
                  cnt_q    <= 3'd0;
                  mem_wr_q <= 1'b0;
                end else begin
                  mem_wr_q   <= 1'b1;
                  mem_dout_q <= lsb_wdata_i[7:0];
                end
              end else begin
                state_q  <= LS_RD;
                mem_wr_q <= 1'b0;
              end
            end else begin
              last_grant_q <= G_ICACHE;
              addr_q       <= icache_addr_i;
              nbytes_q     <= 3'd4;
              state_q      <= IF_RD;
              mem_wr_q     <= 1'b0;
            end
          end
        end

        IF_RD, LS_RD: begin
          if (jump_wrong_i) begin
            state_q  <= IDLE;
            mem_wr_q <= 1'b0;
          end else begin
            if (cnt_q < nbytes_q) mem_a_q <= addr_q + ADDR_W'(cnt_q);
            if (cnt_q >= 3'd2)    buf_q   <= rd_word;
            if (cnt_q == nbytes_q + 3'd1) begin
              state_q <= DONE;
              if (state_q == IF_RD) begin
                icache_done_q <= 1'b1;
                icache_data_q <= rd_word;
              end else begin
                lsb_done_q  <= 1'b1;
                lsb_rdata_q <= rd_word;
              end
            end
            cnt_q <= cnt_q + 3'd1;
          end
        end

        LS_WR: begin
          if (cnt_q == nbytes_q) begin
            mem_wr_q   <= 1'b0;
            lsb_done_q <= 1'b1;
            state_q    <= DONE;
          end else if (io_q && io_buffer_full_i) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_a_q    <= addr_q + ADDR_W'(cnt_q);
            mem_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr_q   <= 1'b1;
            cnt_q      <= cnt_q + 3'd1;
          end
        end

        DONE: begin
          // Requesters drop req during this cycle, so nothing is accepted here.
          icache_done_q <= 1'b0;
          lsb_done_q    <= 1'b0;
          state_q       <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy = 1'b1;
  logic        jump = 1'b0;
  logic        icache_req = 1'b0;
  logic [31:0] icache_addr = '0;
  logic        icache_done;
  logic [31:0] icache_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_len = '0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        full = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst_n), .rdy_i(rdy), .jump_wrong_i(jump),
    .icache_req_i(icache_req), .icache_addr_i(icache_addr),
    .icache_done_o(icache_done), .icache_data_o(icache_data),
    .lsb_req_i(lsb_req), .lsb_wr_i(lsb_wr), .lsb_len_i(lsb_len),
    .lsb_addr_i(lsb_addr), .lsb_wdata_i(lsb_wdata),
    .lsb_done_o(lsb_done), .lsb_rdata_o(lsb_rdata),
    .mem_din_i(mem_din), .mem_dout_o(mem_dout), .mem_a_o(mem_a),
    .mem_wr_o(mem_wr), .io_buffer_full_i(full)
  );

  typedef struct packed { logic wr; logic [31:0] d; } lexp_t;

  int n_chk = 0;
  int n_err = 0;

  // ram: what the DUT actually wrote; mdl: what the requests should leave behind
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  mdl [logic [31:0]];
  logic [31:0] ic_q [$];
  lexp_t       ls_q [$];
  logic [39:0] wq   [$];
  logic [31:0] ic_ahist [$];
  int          order [$];

  function automatic logic [7:0] init_b(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_b(a);
  endfunction
  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : init_b(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    mdl[a] = d;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Synchronous byte RAM, clock-enabled by rdy like the rest of the core
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= ram_rd(mem_a);
    end
  end

  // Scoreboard monitor: outputs that persist across rdy=0 count once, on the rdy=1 cycle
  logic [31:0] m_ic;
  lexp_t       m_ls;
  logic [39:0] m_w;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rdy) begin
      if (icache_done) begin
        check("ic_done_expected", 64'(ic_q.size() != 0), 64'd1);
        if (ic_q.size() != 0) begin
          m_ic = ic_q.pop_front();
          check("ic_data", 64'(icache_data), 64'(m_ic));
        end
      end
      if (lsb_done) begin
        check("ls_done_expected", 64'(ls_q.size() != 0), 64'd1);
        if (ls_q.size() != 0) begin
          m_ls = ls_q.pop_front();
          if (!m_ls.wr) check("ls_rdata", 64'(lsb_rdata), 64'(m_ls.d));
        end
      end
      if (mem_wr) begin
        check("wr_expected", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          m_w = wq.pop_front();
          check("wr_addr", 64'(mem_a), 64'(m_w[39:8]));
          check("wr_byte", 64'(mem_dout), 64'(m_w[7:0]));
        end
      end
    end
  end

  // Requester tasks: call just after a negedge; they return on the done negedge.
  task automatic ic_txn(input logic [31:0] a, output int lat);
    logic [31:0] w;
    bit seen;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mdl_rd(a + 32'(k));
    ic_q.push_back(w);
    icache_addr = a;
    icache_req  = 1'b1;
    seen = 1'b0;
    lat  = -1;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(negedge clk);
      ic_ahist.push_back(mem_a);
      if (icache_done && rdy) begin seen = 1'b1; lat = c - 1; end
    end
    icache_req = 1'b0;
    check("ic_done_seen", 64'(seen), 64'd1);
  endtask

  task automatic ls_txn(input logic wr, input logic [1:0] len, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output int nwr);
    int n;
    lexp_t e;
    bit seen;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    e.wr = wr;
    e.d  = '0;
    for (int k = 0; k < n; k++) begin
      if (wr) begin
        wq.push_back({a + 32'(k), wd[8*k +: 8]});
        mdl[a + 32'(k)] = wd[8*k +: 8];
      end else begin
        e.d[8*k +: 8] = mdl_rd(a + 32'(k));
      end
    end
    ls_q.push_back(e);
    lsb_wr = wr; lsb_len = len; lsb_addr = a; lsb_wdata = wd;
    lsb_req = 1'b1;
    seen = 1'b0;
    lat = -1;
    nwr = 0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(negedge clk);
      if (mem_wr && rdy) nwr++;
      if (lsb_done && rdy) begin seen = 1'b1; lat = c - 1; end
    end
    lsb_req = 1'b0;
    check("ls_done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int lat, nwr, lat2, nwr2;
  bit rand_done;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_a", 64'(mem_a), 64'd0);
    check("rst_mem_dout", 64'(mem_dout), 64'd0);
    check("rst_ic_done", 64'(icache_done), 64'd0);
    check("rst_ls_done", 64'(lsb_done), 64'd0);
    check("rst_data", 64'({icache_data, lsb_rdata}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Both requesters busy from reset: grants alternate starting with the LSB
    fork
      for (int i = 0; i < 3; i++) begin
        ic_txn(32'h1100 + 32'(4*i), lat);
        order.push_back(0);
        @(negedge clk);
      end
      for (int i = 0; i < 3; i++) begin
        ls_txn(1'b0, 2'b10, 32'h8000 + 32'(4*i), 32'h0, lat2, nwr2);
        order.push_back(1);
        @(negedge clk);
      end
    join
    check("alt_count", 64'(order.size()), 64'd6);
    for (int i = 0; i < order.size(); i++)
      check("alt_order", 64'(order[i]), (i % 2 == 0) ? 64'd1 : 64'd0);

    // ICache word fetch
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    @(negedge clk);
    ic_ahist.delete();
    ic_txn(32'h100, lat);
    check("ic_lat", 64'(lat), 64'd5);
    for (int k = 0; k < 4; k++) check("ic_mem_a_seq", 64'(ic_ahist[k]), 64'(32'h100 + 32'(k)));
    @(negedge clk);
    check("ic_done_one_pulse", 64'(icache_done), 64'd0);

    // Halfword load, word store and read-back, wrap, byte and 2'b11 lengths
    poke(32'h201, 8'hAB); poke(32'h202, 8'hCD);
    ls_txn(1'b0, 2'b01, 32'h201, 32'h0, lat, nwr);
    check("lh_lat", 64'(lat), 64'd3);
    @(negedge clk);
    ls_txn(1'b1, 2'b10, 32'h40, 32'hDEADBEEF, lat, nwr);
    check("sw_lat", 64'(lat), 64'd4);
    check("sw_nwr", 64'(nwr), 64'd4);
    @(negedge clk);
    ls_txn(1'b0, 2'b10, 32'h40, 32'h0, lat, nwr);
    check("lw_lat", 64'(lat), 64'd5);
    @(negedge clk);
    ls_txn(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, lat, nwr);
    check("lw_wrap_lat", 64'(lat), 64'd5);
    @(negedge clk);
    ls_txn(1'b0, 2'b11, 32'h8100, 32'h0, lat, nwr);
    check("len11_lat", 64'(lat), 64'd5);
    @(negedge clk);
    ls_txn(1'b0, 2'b00, 32'h8105, 32'h0, lat, nwr);
    check("lb_lat", 64'(lat), 64'd2);

    // Flush two cycles into an ICache read: aborted, arbiter idle next cycle
    @(negedge clk);
    icache_addr = 32'h500;
    icache_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    jump = 1'b1;
    icache_req = 1'b0;
    @(negedge clk);
    jump = 1'b0;
    check("flush_mem_wr", 64'(mem_wr), 64'd0);
    ls_txn(1'b0, 2'b00, 32'h8123, 32'h0, lat, nwr);
    check("flush_idle_lat", 64'(lat), 64'd2);
    repeat (6) @(negedge clk);

    // Flush during a store is ignored
    fork
      ls_txn(1'b1, 2'b10, 32'h60, 32'h11223344, lat, nwr);
      begin repeat (2) @(negedge clk); jump = 1'b1; @(negedge clk); jump = 1'b0; end
    join
    check("flush_sw_lat", 64'(lat), 64'd4);
    check("flush_sw_nwr", 64'(nwr), 64'd4);

    // Flush at the accept edge: store still accepted, read deferred one cycle
    @(negedge clk);
    jump = 1'b1;
    fork
      ls_txn(1'b1, 2'b00, 32'h70, 32'h0000_0077, lat, nwr);
      begin @(negedge clk); jump = 1'b0; end
    join
    check("flush_idle_sb_lat", 64'(lat), 64'd1);
    @(negedge clk);
    jump = 1'b1;
    fork
      ic_txn(32'h1300, lat);
      begin @(negedge clk); jump = 1'b0; end
    join
    check("flush_idle_ic_lat", 64'(lat), 64'd6);

    // IO store stalled for three cycles; non-IO store ignores the full flag
    @(negedge clk);
    full = 1'b1;
    fork
      ls_txn(1'b1, 2'b00, 32'h30000, 32'h0000_00A5, lat, nwr);
      begin repeat (3) @(negedge clk); full = 1'b0; end
    join
    check("io_stall_lat", 64'(lat), 64'd4);
    check("io_stall_nwr", 64'(nwr), 64'd1);
    @(negedge clk);
    full = 1'b1;
    ls_txn(1'b1, 2'b00, 32'h2000, 32'h0000_005C, lat, nwr);
    full = 1'b0;
    check("nonio_full_lat", 64'(lat), 64'd1);

    // Random traffic with rdy and io_buffer_full toggling
    @(negedge clk);
    rand_done = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 60; i++) begin
            ic_txn(32'h1000 + 32'($urandom_range(0, 4091)), lat);
            repeat ($urandom_range(1, 3)) @(negedge clk);
          end
          for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 32'h30000 + 32'($urandom_range(0, 7))
                                              : 32'h8000 + 32'($urandom_range(0, 255));
            ls_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom, lat2, nwr2);
            repeat ($urandom_range(1, 3)) @(negedge clk);
          end
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          rdy  = ($urandom_range(0, 99) < 85);
          full = ($urandom_range(0, 99) < 30);
        end
        rdy  = 1'b1;
        full = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("ic_q_empty", 64'(ic_q.size()), 64'd0);
    check("ls_q_empty", 64'(ls_q.size()), 64'd0);
    check("wq_empty", 64'(wq.size()), 64'd0);

    // Reset in the middle of a read clears every output at once
    icache_addr = 32'h1200;
    icache_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_a", 64'(mem_a), 64'd0);
    check("midrst_mem_wr", 64'(mem_wr), 64'd0);
    check("midrst_ic_data", 64'(icache_data), 64'd0);
    check("midrst_outs", 64'({icache_done, lsb_done, mem_dout, lsb_rdata}), 64'd0);
    icache_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ic_txn(32'h1400, lat);
    check("post_rst_ic_lat", 64'(lat), 64'd5);
    repeat (2) @(negedge clk);
    check("final_ic_q_empty", 64'(ic_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
